// File: rtl/input_sr.sv
// Input shift buffer: collects narrow words from a stream and hands them to
// memory in pairs, or as a lone word when flushed.
module input_sr #(
  parameter int DWIDTH = 16,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DWIDTH-1:0]     data_in,
  input  logic                  wen,
  input  logic                  flush,
  input  logic                  mem_rdy,
  output logic [2*DWIDTH-1:0]   data_out,
  output logic                  wen_w2,
  output logic                  wen_w1,
  output logic                  full,
  output logic                  overflow,
  output logic [2:0]            count
);

  logic [DWIDTH-1:0]   mem_q [4];
  logic [1:0]          wr_q, wr_d;
  logic [1:0]          rd_q, rd_d;
  logic [1:0]          rd_n1;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          pop_n;
  logic                ovf_q, ovf_d;
  logic                w1_q, w1_d;
  logic                w2_q, w2_d;
  logic [2*DWIDTH-1:0] dout_q, dout_d;
  logic                push, pair, single;

  assign full  = (cnt_q == 3'(DEPTH));
  assign rd_n1 = rd_q + 2'd1;

  always_comb begin
    push   = wen && !full;
    pair   = mem_rdy && (cnt_q >= 3'd2);
    single = mem_rdy && flush && (cnt_q == 3'd1);
  end

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    ovf_d  = ovf_q | (wen & full);
    w1_d   = 1'b0;
    w2_d   = 1'b0;
    dout_d = dout_q;
    pop_n  = 3'd0;
    if (push)
      wr_d = wr_q + 2'd1;
    // Pairs win over flush; a single pop only drains a lone word.
    if (pair) begin
      dout_d = {mem_q[rd_n1], mem_q[rd_q]};
      rd_d   = rd_q + 2'd2;
      w2_d   = 1'b1;
      pop_n  = 3'd2;
    end else if (single) begin
      dout_d = {{DWIDTH{1'b0}}, mem_q[rd_q]};
      rd_d   = rd_n1;
      w1_d   = 1'b1;
      pop_n  = 3'd1;
    end
    cnt_d = cnt_q + {2'b00, push} - pop_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      w1_q   <= 1'b0;
      w2_q   <= 1'b0;
      dout_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      w1_q   <= w1_d;
      w2_q   <= w2_d;
      dout_q <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= data_in;
  end

  assign data_out = dout_q;
  assign wen_w1   = w1_q;
  assign wen_w2   = w2_q;
  assign overflow = ovf_q;
  assign count    = cnt_q;

endmodule

// File: tb/tb_input_sr.sv
// Bench for input_sr: queue-based model, scoreboard of emitted words,
// directed scenarios followed by random traffic.
module tb_input_sr;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          wen = 1'b0;
  logic          flush = 1'b0;
  logic          mem_rdy = 1'b0;
  logic [2*DW-1:0] data_out;
  logic          wen_w2, wen_w1, full, overflow;
  logic [2:0]    count;

  always #5 clk = ~clk;

  input_sr #(.DWIDTH(DW), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .wen(wen),
    .flush(flush), .mem_rdy(mem_rdy), .data_out(data_out),
    .wen_w2(wen_w2), .wen_w1(wen_w1), .full(full),
    .overflow(overflow), .count(count)
  );

  typedef struct packed {
    logic [2:0]  cnt;
    logic        full;
    logic        ovf;
    logic        w1;
    logic        w2;
    logic [31:0] dout;
  } st_t;

  st_t           st_q[$];
  logic [31:0]   exp_q[$];
  logic [DW-1:0] mq[$];
  logic          m_ovf = 1'b0;
  logic [31:0]   m_dout = '0;
  int            nerr = 0;
  int            nchk = 0;
  bit            mon_en = 1'b0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // One clock of stimulus; the model advances on the word queue.
  task automatic step(input logic w, input logic [DW-1:0] d,
                      input logic f, input logic m);
    st_t s;
    int  n;
    bit  fl;
    @(negedge clk);
    wen = w; data_in = d; flush = f; mem_rdy = m;
    n = mq.size();
    fl = (n == 4);
    s.w1 = 1'b0;
    s.w2 = 1'b0;
    if (m && n >= 2) begin
      m_dout = {mq[1], mq[0]};
      void'(mq.pop_front());
      void'(mq.pop_front());
      s.w2 = 1'b1;
      exp_q.push_back(m_dout);
    end else if (m && f && n == 1) begin
      m_dout = {16'h0000, mq[0]};
      void'(mq.pop_front());
      s.w1 = 1'b1;
      exp_q.push_back(m_dout);
    end
    if (w) begin
      if (fl) m_ovf = 1'b1;
      else mq.push_back(d);
    end
    s.cnt  = 3'(mq.size());
    s.full = (mq.size() == 4);
    s.ovf  = m_ovf;
    s.dout = m_dout;
    st_q.push_back(s);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_cnt"}, 32'(count), 32'd0);
    chk({n, "_w1"}, 32'(wen_w1), 32'd0);
    chk({n, "_w2"}, 32'(wen_w2), 32'd0);
    chk({n, "_ovf"}, 32'(overflow), 32'd0);
    chk({n, "_dout"}, data_out, 32'd0);
  endtask

  // Async reset asserted mid-cycle, released shortly after an edge.
  task automatic do_reset(input string n);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    reset = 1'b1;
    wen = 1'b0; flush = 1'b0; mem_rdy = 1'b0;
    #1;
    chk_zero(n);
    mq.delete();
    exp_q.delete();
    st_q.delete();
    m_ovf = 1'b0;
    m_dout = '0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin : mon
    st_t s;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (st_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL status_queue: got empty expected entry");
        end else begin
          s = st_q.pop_front();
          chk("count", 32'(count), 32'(s.cnt));
          chk("full", 32'(full), 32'(s.full));
          chk("overflow", 32'(overflow), 32'(s.ovf));
          chk("pulses", 32'({wen_w2, wen_w1}), 32'({s.w2, s.w1}));
          if (wen_w1 || wen_w2) begin
            if (exp_q.size() == 0) begin
              nchk++; nerr++;
              $display("FAIL data: got %h expected none", data_out);
            end else begin
              chk("data", data_out, exp_q.pop_front());
            end
          end else begin
            chk("hold", data_out, s.dout);
          end
        end
      end
    end
  end

  initial begin
    #1;
    chk_zero("por");
    @(posedge clk);
    #2;
    reset = 1'b0;
    mon_en = 1'b1;

    // pair of two words
    step(1, 16'h1111, 0, 1);
    step(1, 16'h2222, 0, 1);
    step(0, 16'h0, 0, 1);
    step(0, 16'h0, 0, 1);

    // fill past capacity
    for (int i = 0; i < 5; i++) step(1, 16'(16'hA0 + i), 0, 0);
    @(posedge clk);
    #2;
    chk("s34_full", 32'(full), 32'd1);
    chk("s34_ovf", 32'(overflow), 32'd1);

    // drain across pointer wrap
    step(0, 16'h0, 0, 1);
    step(0, 16'h0, 0, 1);
    step(0, 16'h0, 0, 1);

    // lone word flush, then flush on empty
    step(1, 16'hBEEF, 0, 0);
    step(0, 16'h0, 1, 1);
    step(0, 16'h0, 1, 1);
    step(0, 16'h0, 1, 0);

    // pop and push together with three buffered
    step(1, 16'h3001, 0, 0);
    step(1, 16'h3002, 0, 0);
    step(1, 16'h3003, 0, 0);
    step(1, 16'h5555, 0, 1);
    step(0, 16'h0, 1, 1);
    step(0, 16'h0, 0, 0);

    // reset mid-operation with three buffered
    step(1, 16'h7001, 0, 0);
    step(1, 16'h7002, 0, 0);
    step(1, 16'h7003, 0, 0);
    do_reset("mid_rst");
    step(1, 16'h8001, 0, 0);
    step(1, 16'h8002, 0, 1);
    step(0, 16'h0, 0, 1);
    step(0, 16'h0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 6), 16'($urandom()),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 5));
      if (i == 300) do_reset("rnd_rst");
    end
    for (int i = 0; i < 4; i++) step(0, 16'h0, 1, 1);

    @(posedge clk);
    #2;
    mon_en = 1'b0;
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    chk("st_left", 32'(st_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/input_sr.md
INPUT_SR -- requirements
Module: input_sr

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, input word width; output word width is 2*DWIDTH.
REQ-002 SHALL have parameter DEPTH, default 4, buffer depth in words; fixed at 4 for this revision, with 2-bit pointers.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_in  input  DWIDTH  input word from the upstream stream.
REQ-006 SHALL have port wen  input  1  write strobe for data_in.
REQ-007 SHALL have port flush  input  1  request to emit a lone pending word.
REQ-008 SHALL have port mem_rdy  input  1  downstream memory can accept a write this cycle.
REQ-009 SHALL have port data_out  output  2*DWIDTH  packed word: older word in [DWIDTH-1:0], newer word in the upper half.
REQ-010 SHALL have port wen_w2  output  1  data_out holds two valid words (one-cycle pulse).
REQ-011 SHALL have port wen_w1  output  1  only data_out[DWIDTH-1:0] is valid; upper half is 0 (one-cycle pulse).
REQ-012 SHALL have port full  output  1  buffer count equals DEPTH (combinational from count).
REQ-013 SHALL have port overflow  output  1  sticky flag: a write was dropped.
REQ-014 SHALL have port count  output  3  number of words currently buffered (0..4).

Function
REQ-015 SHALL keep a 4-entry circular buffer with write pointer, read pointer and count; pointers wrap 3->0.
REQ-016 SHALL define push as wen && !full; on push, store data_in at the write pointer and increment the write pointer.
REQ-017 SHALL ignore wen when full, leave the buffer unchanged and set overflow to 1 at that edge.
REQ-018 SHALL define pair-pop as mem_rdy && count>=2.
REQ-019 On pair-pop, SHALL register data_out = {buf[rd+1], buf[rd]}, set wen_w2=1 for the next cycle, and advance the read pointer by 2 with wrap.
REQ-020 SHALL define single-pop as mem_rdy && flush && count==1.
REQ-021 On single-pop, SHALL register data_out = {0, buf[rd]}, set wen_w1=1 for the next cycle, and advance the read pointer by 1.
REQ-022 Pair-pop SHALL take priority over flush; flush with count>=2 SHALL produce only a pair-pop that cycle.
REQ-023 flush with count==0, or with mem_rdy=0, SHALL have no effect; flush is not latched.
REQ-024 SHALL deassert wen_w1 and wen_w2 in any cycle following an edge with no pop; they SHALL never both be 1.
REQ-025 SHALL hold data_out at its last value when no pop occurs.
REQ-026 SHALL update count_next = count + push - (2 if pair-pop, 1 if single-pop, else 0) when push and pop occur in the same cycle.
REQ-027 Pop decisions SHALL use the count before the edge; a word pushed at edge N SHALL first be eligible for pop at edge N+1 (no bypass).
REQ-028 full SHALL be evaluated before the edge; push while full SHALL be refused even if a pop occurs in the same cycle.
REQ-029 Latency: words pushed at edges N and N+1, with mem_rdy=1 -> pair-pop at edge N+2, wen_w2 high during cycle N+2..N+3.

Reset
REQ-030 On reset=1, without waiting for clk, SHALL clear pointers, count, overflow, wen_w1, wen_w2 and data_out to 0.
REQ-031 Buffered words SHALL be discarded on reset mid-operation; the first push after release SHALL land in entry 0.
REQ-032 Buffer storage contents need not be reset.

Verification
REQ-033 Scenario: push 0x1111 then 0x2222 with mem_rdy=1 -> one cycle with wen_w2=1, data_out=0x22221111, then count=0.
REQ-034 Scenario: mem_rdy=0, push 5 words 0xA0..0xA4 -> full=1 after the 4th push, 0xA4 dropped, overflow=1 until reset.
REQ-035 Scenario: continuing from REQ-034 with mem_rdy=1 -> data_out 0x00A100A0 then 0x00A300A2, across pointer wrap.
REQ-036 Scenario: push 0xBEEF alone, flush=1 with mem_rdy=1 -> wen_w1=1, data_out=0x0000BEEF, count=0; flush with count=0 -> no pulse.
REQ-037 Scenario: count=3, pair-pop plus push of 0x5555 in the same cycle -> count=2, and the next pair contains the old third word and 0x5555.
REQ-038 Scenario: assert reset asynchronously mid-cycle with count=3 -> count, pulses, overflow and data_out read 0 immediately.
